// File: rtl/bht_gshare.sv
// Gshare direction predictor: 2-bit saturating counters indexed by PC XOR global history,
// with a speculative GHR that is checkpointed at predict time and restored on mispredict.
module bht_gshare #(
    parameter int unsigned VLEN       = 64,
    parameter int unsigned NR_ENTRIES = 128,
    parameter int unsigned HIST_BITS  = 3,
    parameter int unsigned ALIGN_BITS = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 pred_valid_i,
    input  logic [VLEN-1:0]      pred_pc_i,
    output logic                 pred_taken_o,
    output logic [HIST_BITS-1:0] pred_ghr_o,
    input  logic                 upd_valid_i,
    input  logic [VLEN-1:0]      upd_pc_i,
    input  logic [HIST_BITS-1:0] upd_ghr_i,
    input  logic                 upd_taken_i,
    input  logic                 upd_mispredict_i
);

    localparam int unsigned IDX_W = $clog2(NR_ENTRIES);

    logic [1:0]           cnt_q [NR_ENTRIES];
    logic [HIST_BITS-1:0] ghr_q;
    logic [HIST_BITS-1:0] ghr_d;
    logic [IDX_W-1:0]     pred_idx_s;
    logic [IDX_W-1:0]     upd_idx_s;
    logic                 unused_pc_s;

    // Saturating increment on taken, saturating decrement on not-taken.
    function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
        end else begin
            nxt = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
        end
        return nxt;
    endfunction

    // Shift one outcome into the history; truncation keeps this valid for HIST_BITS == 1.
    function automatic logic [HIST_BITS-1:0] shift_in(input logic [HIST_BITS-1:0] hist,
                                                      input logic outcome);
        logic [HIST_BITS:0] wide;
        wide = {hist, outcome};
        return wide[HIST_BITS-1:0];
    endfunction

    assign pred_idx_s = pred_pc_i[ALIGN_BITS +: IDX_W] ^ IDX_W'(ghr_q);
    assign upd_idx_s  = upd_pc_i[ALIGN_BITS +: IDX_W] ^ IDX_W'(upd_ghr_i);

    assign pred_taken_o = cnt_q[pred_idx_s][1];
    assign pred_ghr_o   = ghr_q;

    assign unused_pc_s = ^{pred_pc_i[VLEN-1:ALIGN_BITS+IDX_W], pred_pc_i[ALIGN_BITS-1:0],
                           upd_pc_i[VLEN-1:ALIGN_BITS+IDX_W], upd_pc_i[ALIGN_BITS-1:0]};

    // GHR next state: a mispredict restore outranks flush, which outranks speculation.
    always_comb begin
        ghr_d = ghr_q;
        if (upd_valid_i && upd_mispredict_i) begin
            ghr_d = shift_in(upd_ghr_i, upd_taken_i);
        end else if (flush_i) begin
            ghr_d = '0;
        end else if (pred_valid_i) begin
            ghr_d = shift_in(ghr_q, pred_taken_o);
        end else begin
            ghr_d = ghr_q;
        end
    end

    // Counter array and GHR state; the predict read above sees the pre-update counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ghr_q <= '0;
            for (int i = 0; i < int'(NR_ENTRIES); i++) begin
                cnt_q[i] <= 2'b01;
            end
        end else begin
            ghr_q <= ghr_d;
            if (upd_valid_i) begin
                cnt_q[upd_idx_s] <= sat_next(cnt_q[upd_idx_s], upd_taken_i);
            end
        end
    end

endmodule

// File: tb/tb_bht_gshare.sv
// Directed-vector bench for bht_gshare: the driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the predict port.
module tb_bht_gshare;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        pred_valid_i = 1'b0;
    logic [63:0] pred_pc_i = 64'h0;
    logic        pred_taken_o;
    logic [2:0]  pred_ghr_o;
    logic        upd_valid_i = 1'b0;
    logic [63:0] upd_pc_i = 64'h0;
    logic [2:0]  upd_ghr_i = 3'b000;
    logic        upd_taken_i = 1'b0;
    logic        upd_mispredict_i = 1'b0;

    typedef struct {
        string      nm;
        logic       taken;
        logic [2:0] ghr;
    } exp_t;

    exp_t q[$];
    bit   chk_en = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [63:0] PC0  = 64'h0000_0000_8000_0000; // idx 0
    localparam logic [63:0] PC2  = 64'h0000_0000_8000_0004; // idx 2
    localparam logic [63:0] PC8  = 64'h0000_0000_8000_0010; // idx 8
    localparam logic [63:0] PC9  = 64'h0000_0000_8000_0012; // idx 9
    localparam logic [63:0] PC15 = 64'h0000_0000_8000_001E; // idx 15

    bht_gshare #(.VLEN(64), .NR_ENTRIES(128), .HIST_BITS(3), .ALIGN_BITS(1)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .flush_i         (flush_i),
        .pred_valid_i    (pred_valid_i),
        .pred_pc_i       (pred_pc_i),
        .pred_taken_o    (pred_taken_o),
        .pred_ghr_o      (pred_ghr_o),
        .upd_valid_i     (upd_valid_i),
        .upd_pc_i        (upd_pc_i),
        .upd_ghr_i       (upd_ghr_i),
        .upd_taken_i     (upd_taken_i),
        .upd_mispredict_i(upd_mispredict_i)
    );

    always #5 clk = ~clk;

    // Monitor: compare the predict port mid-cycle whenever the driver flagged a check.
    always @(negedge clk) begin
        if (chk_en) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scoreboard_underflow: check strobe with no expected entry");
            end else begin
                exp_t e;
                e = q.pop_front();
                n_cmp++;
                if (pred_taken_o !== e.taken || pred_ghr_o !== e.ghr) begin
                    n_bad++;
                    $display("FAIL %s: got taken=%0b ghr=%03b, expected taken=%0b ghr=%03b",
                             e.nm, pred_taken_o, pred_ghr_o, e.taken, e.ghr);
                end
            end
        end
    end

    // One cycle of stimulus, applied just after the rising edge.
    task automatic step(input bit rst, input bit fl, input bit pv, input logic [63:0] ppc,
                        input bit uv, input bit um, input bit ut, input logic [63:0] upc,
                        input logic [2:0] ughr, input bit chk, input bit et,
                        input logic [2:0] eg, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst_i            = rst;
        flush_i          = fl;
        pred_valid_i     = pv;
        pred_pc_i        = ppc;
        upd_valid_i      = uv;
        upd_mispredict_i = um;
        upd_taken_i      = ut;
        upd_pc_i         = upc;
        upd_ghr_i        = ughr;
        chk_en           = chk;
        if (chk) begin
            e.nm = nm;
            e.taken = et;
            e.ghr = eg;
            q.push_back(e);
        end
    endtask

    // Predict-only observation at a given PC.
    task automatic look(input logic [63:0] ppc, input bit et, input logic [2:0] eg,
                        input string nm);
        step(1'b0, 1'b0, 1'b0, ppc, 1'b0, 1'b0, 1'b0, 64'h0, 3'b000, 1'b1, et, eg, nm);
    endtask

    // Non-mispredict update of PC8 with checkpoint 0, predicting the same index.
    task automatic upd8(input bit ut, input bit et, input string nm);
        step(1'b0, 1'b0, 1'b0, PC8, 1'b1, 1'b0, ut, PC8, 3'b000, 1'b1, et, 3'b000, nm);
    endtask

    initial begin
        step(1'b1, 1'b0, 1'b0, PC0, 1'b0, 1'b0, 1'b0, 64'h0, 3'b000, 1'b0, 1'b0, 3'b000, "");
        step(1'b1, 1'b0, 1'b0, PC0, 1'b0, 1'b0, 1'b0, 64'h0, 3'b000, 1'b0, 1'b0, 3'b000, "");
        look(PC0, 1'b0, 3'b000, "reset_state");

        // Saturation at idx 8; each check sees the counter before that cycle's update.
        upd8(1'b1, 1'b0, "sat_t1_01");
        upd8(1'b1, 1'b1, "sat_t2_10");
        upd8(1'b1, 1'b1, "sat_t3_11");
        look(PC8, 1'b1, 3'b000, "sat_hi_hold");
        upd8(1'b0, 1'b1, "sat_nt1_11");
        upd8(1'b0, 1'b1, "sat_nt2_10");
        look(PC8, 1'b0, 3'b000, "sat_nt_to_01");
        upd8(1'b0, 1'b0, "sat_nt3_01");
        upd8(1'b0, 1'b0, "sat_nt4_00");
        upd8(1'b0, 1'b0, "sat_nt5_00");
        upd8(1'b1, 1'b0, "sat_lo_hold");
        look(PC8, 1'b0, 3'b000, "sat_lo_plus1");

        // Train idx 0 and 2 weakly taken, leave idx 1 at 01.
        step(1'b0, 1'b0, 1'b0, PC0, 1'b1, 1'b0, 1'b1, PC0, 3'b000, 1'b0, 1'b0, 3'b000, "");
        step(1'b0, 1'b0, 1'b0, PC0, 1'b1, 1'b0, 1'b1, PC2, 3'b000, 1'b0, 1'b0, 3'b000, "");
        step(1'b0, 1'b0, 1'b1, PC0, 1'b0, 1'b0, 1'b0, 64'h0, 3'b000, 1'b1, 1'b1, 3'b000, "spec_p1");
        step(1'b0, 1'b0, 1'b1, PC0, 1'b0, 1'b0, 1'b0, 64'h0, 3'b000, 1'b1, 1'b0, 3'b001, "spec_p2");
        step(1'b0, 1'b0, 1'b1, PC0, 1'b0, 1'b0, 1'b0, 64'h0, 3'b000, 1'b1, 1'b1, 3'b010, "spec_p3");
        look(PC0, 1'b0, 3'b101, "spec_ghr_101");

        // Mispredict restore beats flush and prediction in the same cycle.
        step(1'b0, 1'b1, 1'b1, PC0, 1'b1, 1'b1, 1'b1, PC0, 3'b010, 1'b1, 1'b0, 3'b101, "mp_cycle");
        step(1'b0, 1'b0, 1'b0, PC0, 1'b0, 1'b1, 1'b1, PC0, 3'b011, 1'b1, 1'b0, 3'b101, "mp_restored");
        step(1'b0, 1'b0, 1'b1, PC0, 1'b1, 1'b1, 1'b0, PC0, 3'b011, 1'b1, 1'b0, 3'b101, "mp_no_valid_ignored");
        step(1'b0, 1'b1, 1'b1, PC0, 1'b0, 1'b0, 1'b0, 64'h0, 3'b000, 1'b1, 1'b0, 3'b110, "mp_restore_110");
        look(PC0, 1'b1, 3'b000, "flush_over_pred");

        // Collision: read-before-write at idx 8 (counter 01).
        upd8(1'b1, 1'b0, "collide_old");
        look(PC8, 1'b1, 3'b000, "collide_new");

        // Train idx 8 to 11 and set GHR to 111, then reset mid-operation.
        step(1'b0, 1'b0, 1'b0, PC8, 1'b1, 1'b0, 1'b1, PC8, 3'b000, 1'b0, 1'b0, 3'b000, "");
        step(1'b0, 1'b0, 1'b0, PC8, 1'b1, 1'b1, 1'b1, PC8, 3'b011, 1'b0, 1'b0, 3'b000, "");
        look(PC15, 1'b1, 3'b111, "pre_reset_trained");
        step(1'b1, 1'b1, 1'b1, PC15, 1'b1, 1'b1, 1'b1, PC8, 3'b011, 1'b0, 1'b0, 3'b000, "");
        look(PC15, 1'b0, 3'b000, "post_reset_idx15");
        look(PC8, 1'b0, 3'b000, "post_reset_idx8");
        look(PC0, 1'b0, 3'b000, "post_reset_idx0");

        // Flush clears GHR only.
        step(1'b0, 1'b0, 1'b0, PC8, 1'b1, 1'b0, 1'b1, PC8, 3'b000, 1'b0, 1'b0, 3'b000, "");
        step(1'b0, 1'b0, 1'b0, PC8, 1'b1, 1'b0, 1'b1, PC8, 3'b000, 1'b0, 1'b0, 3'b000, "");
        step(1'b0, 1'b0, 1'b1, PC8, 1'b0, 1'b0, 1'b0, 64'h0, 3'b000, 1'b1, 1'b1, 3'b000, "flush_pre_pred");
        step(1'b0, 1'b1, 1'b0, PC9, 1'b0, 1'b0, 1'b0, 64'h0, 3'b000, 1'b1, 1'b1, 3'b001, "flush_cycle");
        look(PC8, 1'b1, 3'b000, "flush_keeps_counters");

        step(1'b0, 1'b0, 1'b0, PC0, 1'b0, 1'b0, 1'b0, 64'h0, 3'b000, 1'b0, 1'b0, 3'b000, "");
        @(posedge clk);
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_leftover: %0d entries left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
